// File: rtl/four_bit_pkg.sv
// Shared definitions for the 4-bit computer and its program loader: opcodes,
// the loader state set and the layout of a 12-bit program word.
package four_bit_pkg;

  localparam int WORD_W   = 12;
  localparam int FIELD_W  = 4;
  localparam int SLOT_W   = 4;
  localparam int INST_LSB = 8;
  localparam int DATA_LSB = 4;
  localparam int MEM_LSB  = 0;

  localparam logic [SLOT_W-1:0] LAST_SLOT = 4'hF;

  localparam logic [FIELD_W-1:0] NOP = 4'h0;
  localparam logic [FIELD_W-1:0] LDA = 4'h1;
  localparam logic [FIELD_W-1:0] ADD = 4'h2;
  localparam logic [FIELD_W-1:0] SUB = 4'h3;
  localparam logic [FIELD_W-1:0] STA = 4'h4;
  localparam logic [FIELD_W-1:0] LDI = 4'h5;
  localparam logic [FIELD_W-1:0] JMP = 4'h6;
  localparam logic [FIELD_W-1:0] OUT = 4'hE;
  localparam logic [FIELD_W-1:0] HLT = 4'hF;

  // CHK and ERR only exist when the checksum option is built in.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PAD   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_RUN   = 3'd4
`ifdef LOADER_CHKSUM_EN
    , ST_CHK = 3'd5,
    ST_ERR   = 3'd6
`endif
  } loader_state_e;

  typedef struct packed {
    logic [FIELD_W-1:0] inst;
    logic [FIELD_W-1:0] data;
    logic [FIELD_W-1:0] mem;
  } slot_t;

  function automatic slot_t split_word(input logic [WORD_W-1:0] word);
    slot_t s;
    s.inst = word[INST_LSB +: FIELD_W];
    s.data = word[DATA_LSB +: FIELD_W];
    s.mem  = word[MEM_LSB  +: FIELD_W];
    return s;
  endfunction

endpackage

// File: rtl/prog_chksum.sv
// 12-bit XOR accumulator over transferred program words; only built when
// LOADER_CHKSUM_EN is defined.
`ifdef LOADER_CHKSUM_EN
module prog_chksum
  import four_bit_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] sum
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (enable) begin
      sum <= sum ^ word;
    end
  end

endmodule
`endif

// File: rtl/program_loader.sv
// Streams up to 16 program words into the 4-bit computer's load port, pads the
// rest with HLT, then releases the computer. LOADER_CHKSUM_EN adds a trailing
// XOR checksum word that must match before the computer is released.
module program_loader
  import four_bit_pkg::*;
#(
  parameter logic [FIELD_W-1:0] PAD_INST = HLT,
  parameter logic [FIELD_W-1:0] PAD_DATA = 4'h0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_last,
  output logic [SLOT_W-1:0]  prog_count,
  output logic [FIELD_W-1:0] prog_inst,
  output logic [FIELD_W-1:0] prog_data,
  output logic [FIELD_W-1:0] mem_data,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  loader_state_e     state, state_next;
  logic [SLOT_W-1:0] counter;
  slot_t             slot;
  logic              xfer;
  logic              restart;
  logic              at_last;

`ifdef LOADER_CHKSUM_EN
  localparam loader_state_e FILLED = ST_CHK;
  logic [WORD_W-1:0] chksum;

  prog_chksum u_chksum (
    .clock  (clock),
    .reset  (reset),
    .clear  (restart),
    .enable (xfer && state == ST_LOAD),
    .word   (in_word),
    .sum    (chksum)
  );

  assign restart = load_start &&
                   (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
`else
  localparam loader_state_e FILLED = ST_FLUSH;
  assign restart = load_start && (state == ST_IDLE || state == ST_RUN);
`endif

  assign xfer      = in_valid && in_ready;
  assign at_last   = (counter == LAST_SLOT);
  assign prog_inst = slot.inst;
  assign prog_data = slot.data;
  assign mem_data  = slot.mem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (load_start) state_next = ST_LOAD;
      ST_LOAD: begin
        if (xfer) begin
          if (at_last)      state_next = FILLED;
          else if (in_last) state_next = ST_PAD;
        end
      end
      ST_PAD:   if (at_last) state_next = FILLED;
      ST_FLUSH: state_next = ST_RUN;
      ST_RUN:   if (load_start) state_next = ST_LOAD;
`ifdef LOADER_CHKSUM_EN
      ST_CHK:   if (xfer) state_next = (in_word == chksum) ? ST_FLUSH : ST_ERR;
      ST_ERR:   if (load_start) state_next = ST_LOAD;
`endif
      default:  state_next = ST_IDLE;
    endcase
  end

  // The slot registers stop moving once slot 15 is written, so FLUSH and RUN
  // keep re-presenting slot 15 and the computer's rewrites are harmless.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter    <= '0;
      prog_count <= '0;
      slot       <= '0;
    end else if (restart) begin
      counter <= '0;
    end else if ((state == ST_LOAD && xfer) || state == ST_PAD) begin
      prog_count <= counter;
      slot       <= (state == ST_LOAD) ? split_word(in_word)
                                       : slot_t'{inst: PAD_INST, data: PAD_DATA, mem: PAD_DATA};
      if (!at_last) counter <= counter + 1'b1;
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    unique case (state)
      ST_LOAD:  begin in_ready = 1'b1; busy = 1'b1; end
      ST_PAD:   busy = 1'b1;
      ST_FLUSH: busy = 1'b1;
      ST_RUN:   begin done = 1'b1; cpu_reset = 1'b0; end
`ifdef LOADER_CHKSUM_EN
      ST_CHK:   begin in_ready = 1'b1; busy = 1'b1; end
      ST_ERR:   error = 1'b1;
`endif
      default:  ;
    endcase
  end

endmodule
